// File: rtl/booth_div.sv
`default_nettype none
// ============================================================================
// Module     : booth_div
// Description: Sequential signed restoring divider, one quotient bit per clock.
//              Produces truncated {remainder, quotient} with a divide-by-zero flag.
// Revision   : 1.0 - initial release
// ============================================================================
module booth_div #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               parser_done,
  output logic [2*WIDTH-1:0] result,
  output logic               alu_done,
  output logic               div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH:0]     r_r;
  logic               r_sa;
  logic               r_sb;
  logic [2*WIDTH-1:0] r_result;
  logic               r_dbz;

  logic               w_b_zero;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH+1:0]   w_shift;
  logic [WIDTH+1:0]   w_trial;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  // Magnitudes are unsigned, so the most negative operand maps to 2^(WIDTH-1).
  assign w_b_zero = (B == '0);
  assign w_abs_a  = A[WIDTH-1] ? -A : A;
  assign w_abs_b  = B[WIDTH-1] ? -B : B;
  assign w_shift  = {r_r, r_q[WIDTH-1]};
  assign w_trial  = w_shift - {2'b00, r_b};
  assign w_quot   = (r_sa ^ r_sb) ? -r_q : r_q;
  assign w_rem    = r_sa ? -r_r[WIDTH-1:0] : r_r[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (parser_done) begin
      w_next = w_b_zero ? DONE : ITER;
    end else begin
      case (r_state)
        ITER:    if (r_cnt == LAST_STEP) w_next = FIX;
        FIX:     w_next = DONE;
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_q      <= '0;
      r_b      <= '0;
      r_r      <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_result <= '0;
      r_dbz    <= 1'b0;
    end else if (parser_done) begin
      r_q   <= w_abs_a;
      r_b   <= w_abs_b;
      r_sa  <= A[WIDTH-1];
      r_sb  <= B[WIDTH-1];
      r_r   <= '0;
      r_cnt <= '0;
      if (w_b_zero) begin
        r_result <= {A, {WIDTH{1'b1}}};
        r_dbz    <= 1'b1;
      end else begin
        r_dbz <= 1'b0;
      end
    end else begin
      case (r_state)
        ITER: begin
          r_cnt <= r_cnt + CW'(1);
          // A set sign bit means the trial subtraction went negative: restore.
          r_q   <= {r_q[WIDTH-2:0], ~w_trial[WIDTH+1]};
          r_r   <= w_trial[WIDTH+1] ? w_shift[WIDTH:0] : w_trial[WIDTH:0];
        end
        FIX:     r_result <= {w_rem, w_quot};
        default: r_result <= r_result;
      endcase
    end
  end

  assign result      = r_result;
  assign alu_done    = (r_state == DONE);
  assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_booth_div.sv
`default_nettype none
// ============================================================================
// Module     : tb_booth_div
// Description: Self-checking bench for booth_div: vector table, corner sequences
//              and random operands against a truncating-division model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_booth_div;

  logic        clk;
  logic        rst;
  logic [15:0] A;
  logic [15:0] B;
  logic        parser_done;
  logic [31:0] result;
  logic        alu_done;
  logic        div_by_zero;

  int tests;
  int fails;
  logic [31:0] prev_res;

  typedef struct {
    logic [31:0] res;
    logic        dbz;
    int          lat;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] res;
    logic        dbz;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];

  booth_div #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .A           (A),
    .B           (B),
    .parser_done (parser_done),
    .result      (result),
    .alu_done    (alu_done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int ia, ib, q, r;
    if (b == 16'h0000) begin
      e.res = {a, 16'hFFFF};
      e.dbz = 1'b1;
      e.lat = 0;
    end else begin
      ia = int'($signed(a));
      ib = int'($signed(b));
      q  = ia / ib;
      r  = ia % ib;
      e.res = {r[15:0], q[15:0]};
      e.dbz = 1'b0;
      e.lat = 17;
    end
    return e;
  endfunction

  // Called at posedge+1. Scrambles operands after the start edge.
  task automatic run_div(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] eres, input logic edbz);
    exp_t e;
    exp_t got;
    int n;
    e.res = eres;
    e.dbz = edbz;
    e.lat = edbz ? 0 : 17;
    sb.push_back(e);
    A = a;
    B = b;
    parser_done = 1'b1;
    @(posedge clk); #1;
    parser_done = 1'b0;
    A = 16'($urandom);
    B = 16'($urandom);
    if (!edbz) begin
      chk({name, ".start_done"}, {31'b0, alu_done}, 32'd0);
      chk({name, ".start_dbz"}, {31'b0, div_by_zero}, 32'd0);
      chk({name, ".held"}, result, prev_res);
    end
    n = 0;
    while (!alu_done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    got = sb.pop_front();
    chk({name, ".latency"}, n, got.lat);
    chk({name, ".result"}, result, got.res);
    chk({name, ".dbz"}, {31'b0, div_by_zero}, {31'b0, got.dbz});
    prev_res = got.res;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    prev_res = 32'h0;

    vecs[0] = '{16'd100,  16'd7,    32'h0002_000E, 1'b0};
    vecs[1] = '{16'hFF9C, 16'd7,    32'hFFFE_FFF2, 1'b0};
    vecs[2] = '{16'd100,  16'hFFF9, 32'h0002_FFF2, 1'b0};
    vecs[3] = '{16'hFF9C, 16'hFFF9, 32'hFFFE_000E, 1'b0};
    vecs[4] = '{16'd100,  16'h0000, 32'h0064_FFFF, 1'b1};
    vecs[5] = '{16'h8000, 16'hFFFF, 32'h0000_8000, 1'b0};
    vecs[6] = '{16'h8000, 16'h0001, 32'h0000_8000, 1'b0};
    vecs[7] = '{16'd5,    16'h8000, 32'h0005_0000, 1'b0};
    vecs[8] = '{16'h7FFF, 16'h0001, 32'h0000_7FFF, 1'b0};
    vecs[9] = '{16'h0000, 16'd5,    32'h0000_0000, 1'b0};

    rst = 1'b1;
    A = 16'h0;
    B = 16'h0;
    parser_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset.result", result, 32'h0);
    chk("reset.done", {31'b0, alu_done}, 32'd0);
    chk("reset.dbz", {31'b0, div_by_zero}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dbz);
    end

    // Abort 1000/3 five cycles in and restart with 9/4.
    A = 16'd1000;
    B = 16'd3;
    parser_done = 1'b1;
    @(posedge clk); #1;
    parser_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("abort.done_low", {31'b0, alu_done}, 32'd0);
      chk("abort.held", result, prev_res);
    end
    run_div("restart", 16'd9, 16'd4, 32'h0001_0002, 1'b0);

    // Reset in the middle of an iteration run.
    A = 16'd1000;
    B = 16'd3;
    parser_done = 1'b1;
    @(posedge clk); #1;
    parser_done = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst.result", result, 32'h0);
    chk("midrst.done", {31'b0, alu_done}, 32'd0);
    chk("midrst.dbz", {31'b0, div_by_zero}, 32'd0);
    prev_res = 32'h0;
    run_div("after_rst", 16'd1000, 16'd3, 32'h0001_014D, 1'b0);

    // Reset beats a simultaneous start.
    rst = 1'b1;
    A = 16'd5;
    B = 16'd0;
    parser_done = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    parser_done = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_wins.done", {31'b0, alu_done}, 32'd0);
    chk("rst_wins.result", result, 32'h0);
    chk("rst_wins.dbz", {31'b0, div_by_zero}, 32'd0);
    prev_res = 32'h0;

    for (int i = 0; i < 20; i++) begin
      logic [15:0] ra, rb;
      exp_t e;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (rb == 16'h0) rb = 16'h0001;
      e = model(ra, rb);
      run_div($sformatf("rand%0d", i), ra, rb, e.res, e.dbz);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/booth_div.md
Name: booth_div

Overview:
- Sequential signed radix-2 restoring divider, the inverse operation of the calculator's 16-bit Booth multiplier.
- Sits in the UART hex calculator ALU path, beside the multiplier.
- Shares the same handshake: the parser strobes `parser_done`; the block raises `alu_done` with a packed 32-bit result for the UART TX formatter.
- Computes truncated (C-style) quotient and remainder of a signed dividend by a signed divisor, one quotient bit per clock.

Parameters:
- WIDTH, 16, operand width in bits; result is 2*WIDTH. Iteration counter width is ceil(log2(WIDTH))+1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- A  input  WIDTH  dividend, two's complement; sampled only on a start edge
- B  input  WIDTH  divisor, two's complement; sampled only on a start edge
- parser_done  input  1  start strobe, one or more cycles high
- result  output  2*WIDTH  {remainder, quotient}, both two's complement
- alu_done  output  1  result valid, level
- div_by_zero  output  1  set with alu_done when B was 0

Behaviour:
- Clocking: one clock `clk`; reset `rst` is synchronous and active-high. All state updates on the rising edge of `clk`.
- Reset: state=IDLE, counter=0, working registers=0, result=0, alu_done=0, div_by_zero=0. Reset wins over every other input in the same cycle.
- States: IDLE, ITER, FIX, DONE.
- Start (parser_done=1 at an edge, any state, including ITER/FIX/DONE; this aborts any run in progress):
  - latch |A| into the dividend/quotient shift register, |B| into the divisor register, and sign bits sA and sB;
  - clear the partial remainder (WIDTH+1 bits) and the counter;
  - clear alu_done and div_by_zero;
  - go to ITER, or to DONE if B==0.
- Divide by zero, applied on the start edge:
  - result <= {A, all-ones}, div_by_zero <= 1, state <= DONE;
  - alu_done is high from the following cycle.
- ITER, one step per edge:
  - {R,Q} shift left 1;
  - trial = R - |B|;
  - if trial is non-negative: R = trial, Q[0] = 1; else Q[0] = 0.
  - After exactly WIDTH steps, go to FIX.
  - A held-high parser_done restarts on every edge; the run effectively begins at its final high edge.
- FIX, one edge:
  - quotient = (sA ^ sB) ? -Q : Q;
  - remainder = sA ? -R : R, truncated to WIDTH bits;
  - result <= {remainder, quotient}; state <= DONE.
- Latency: start edge E0 -> ITER edges E1..E16 (WIDTH=16) -> FIX at E17 -> alu_done=1 in the cycle after E17.
- DONE: alu_done=1. result and div_by_zero hold until the next start or reset.
- alu_done is 0 in IDLE, ITER and FIX.
- result holds its last value through a new run and changes only at FIX or at a divide-by-zero start.
- Arithmetic:
  - The magnitude of the most negative value (-2^(WIDTH-1)) is handled as an unsigned WIDTH-bit value.
  - -32768 / -1 yields quotient 16'h8000 (wraps) and remainder 0, with no flag.
- Remainder invariant: sign(remainder) == sign(A) or remainder == 0, and |remainder| < |B|.
- Operand changes after the start edge have no effect on the result.

Test Plan:
- Reset, then A=100, B=7, 1-cycle parser_done -> alu_done rises 17 cycles after the start edge, result=32'h0002_000E, div_by_zero=0.
- A=-100 (16'hFF9C), B=7 -> result=32'hFFFE_FFF2 (r=-2, q=-14). A=100, B=-7 -> 32'h0002_FFF2. A=-100, B=-7 -> 32'hFFFE_000E.
- A=100, B=0 -> alu_done high 1 cycle after the start edge, div_by_zero=1, result=32'h0064_FFFF. A following valid start clears div_by_zero on its start edge.
- A=16'h8000, B=16'hFFFF -> result=32'h0000_8000. A=16'h8000, B=16'h0001 -> result=32'h0000_8000. A=5, B=16'h8000 -> result=32'h0005_0000.
- Start 1000/3, restart 5 cycles later with 9/4 -> only result 32'h0001_0002, 17 cycles after the second start. alu_done stays 0 in between and the previous result is held.
- rst asserted mid-ITER -> next cycle result=0, alu_done=0, div_by_zero=0, state IDLE. A new start then completes normally. Random signed A and B (B!=0) versus the reference model q=A/B, r=A%B (truncating).
